// File: rtl/msc_pkg.sv
// Shared constants for the multi-channel sample counter.
package msc_pkg;

  // Counting mode encodings for the shared mode input.
  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  // Default geometry: ten-bit counts, four channels.
  localparam int DEFAULT_NUM_BITS = 10;
  localparam int DEFAULT_NUM_CH   = 4;

  // Typical window length used by the sample datapaths.
  localparam int DEFAULT_WINDOW = 1000;

endpackage : msc_pkg

// File: rtl/multi_sample_counter_chan_counter.sv
// Single counter channel: count, rollover flag, done pulse and sticky overrun.
// Priority per cycle: clear, disabled (rollover_val == 0), cnt_up, hold.
module chan_counter
  import msc_pkg::*;
#(
  parameter int NUM_BITS = DEFAULT_NUM_BITS
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                cnt_up,
  input  logic                clear,
  input  logic                mode,
  input  logic [NUM_BITS-1:0] rollover_val,
  output logic [NUM_BITS-1:0] count,
  output logic                rollover_flag,
  output logic                done_pulse,
  output logic                overrun
);

  localparam logic [NUM_BITS-1:0] CNT_ZERO = {NUM_BITS{1'b0}};
  localparam logic [NUM_BITS-1:0] CNT_ONE  = {{(NUM_BITS-1){1'b0}}, 1'b1};

  logic [NUM_BITS-1:0] count_r;
  logic                flag_r;
  logic                pulse_r;
  logic                overrun_r;

  logic [NUM_BITS-1:0] next_count_s;
  logic                next_flag_s;
  logic                next_pulse_s;
  logic                next_overrun_s;
  logic                at_limit_s;

  // The wrap/hold decision is taken before incrementing, so the count never
  // overflows even with rollover_val at its maximum.
  assign at_limit_s = (count_r >= rollover_val);

  // Next-state computation for count, flag, pulse and overrun.
  always_comb begin
    next_count_s   = count_r;
    next_overrun_s = overrun_r;
    next_flag_s    = 1'b0;
    next_pulse_s   = 1'b0;
    if (clear) begin
      next_count_s   = CNT_ZERO;
      next_overrun_s = 1'b0;
    end else if (rollover_val == CNT_ZERO) begin
      // Disabled channel: strobes are ignored and no flag is produced.
      next_count_s = count_r;
    end else begin
      if (cnt_up) begin
        case (mode)
          MODE_WRAP: begin
            if (at_limit_s) begin
              next_count_s = CNT_ONE;
            end else begin
              next_count_s = count_r + CNT_ONE;
            end
          end
          MODE_ONESHOT: begin
            if (at_limit_s) begin
              next_count_s   = count_r;
              next_overrun_s = 1'b1;
            end else begin
              next_count_s = count_r + CNT_ONE;
            end
          end
          default: begin
            next_count_s = count_r;
          end
        endcase
      end else begin
        next_count_s = count_r;
      end
      next_flag_s  = (next_count_s == rollover_val);
      next_pulse_s = next_flag_s && (count_r != rollover_val);
    end
  end

  // Channel state register with asynchronous reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_r   <= CNT_ZERO;
      flag_r    <= 1'b0;
      pulse_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      count_r   <= next_count_s;
      flag_r    <= next_flag_s;
      pulse_r   <= next_pulse_s;
      overrun_r <= next_overrun_s;
    end
  end

  assign count         = count_r;
  assign rollover_flag = flag_r;
  assign done_pulse    = pulse_r;
  assign overrun       = overrun_r;

endmodule : chan_counter

// File: rtl/multi_sample_counter.sv
// NUM_CH independent sample counters sharing mode and window length.
// all_done is the AND of the registered per-channel rollover flags.
module multi_sample_counter
  import msc_pkg::*;
#(
  parameter int NUM_BITS = DEFAULT_NUM_BITS,
  parameter int NUM_CH   = DEFAULT_NUM_CH
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic [NUM_CH-1:0]          cnt_up,
  input  logic [NUM_CH-1:0]          clear,
  input  logic                       mode,
  input  logic [NUM_BITS-1:0]        rollover_val,
  output logic [NUM_CH*NUM_BITS-1:0] count,
  output logic [NUM_CH-1:0]          rollover_flag,
  output logic [NUM_CH-1:0]          done_pulse,
  output logic [NUM_CH-1:0]          overrun,
  output logic                       all_done
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    chan_counter #(
      .NUM_BITS(NUM_BITS)
    ) u_chan (
      .clk          (clk),
      .n_rst        (n_rst),
      .cnt_up       (cnt_up[i]),
      .clear        (clear[i]),
      .mode         (mode),
      .rollover_val (rollover_val),
      .count        (count[i*NUM_BITS +: NUM_BITS]),
      .rollover_flag(rollover_flag[i]),
      .done_pulse   (done_pulse[i]),
      .overrun      (overrun[i])
    );
  end

  assign all_done = &rollover_flag;

endmodule : multi_sample_counter

// File: tb/tb_multi_sample_counter.sv
// Directed self-checking bench for multi_sample_counter (4 channels, 10 bits).
module tb_multi_sample_counter;

  localparam int NB = 10;
  localparam int NC = 4;

  logic             clk;
  logic             n_rst;
  logic [NC-1:0]    cnt_up;
  logic [NC-1:0]    clear;
  logic             mode;
  logic [NB-1:0]    rollover_val;
  logic [NC*NB-1:0] count;
  logic [NC-1:0]    rollover_flag;
  logic [NC-1:0]    done_pulse;
  logic [NC-1:0]    overrun;
  logic             all_done;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  multi_sample_counter #(.NUM_BITS(NB), .NUM_CH(NC)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .cnt_up       (cnt_up),
    .clear        (clear),
    .mode         (mode),
    .rollover_val (rollover_val),
    .count        (count),
    .rollover_flag(rollover_flag),
    .done_pulse   (done_pulse),
    .overrun      (overrun),
    .all_done     (all_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NB-1:0] cnt(input int ch);
    return count[ch*NB +: NB];
  endfunction

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    cnt_up = 4'b0000;
    clear  = 4'b1111;
    step();
    clear  = 4'b0000;
  endtask

  initial begin
    n_rst = 1'b0; cnt_up = 4'b0000; clear = 4'b0000;
    mode = 1'b0; rollover_val = 10'd1000;
    #12;
    check_value("reset_count", 64'(count), 64'd0);
    check_value("reset_flags", 64'({rollover_flag, done_pulse, overrun, all_done}), 64'd0);
    n_rst = 1'b1;
    step();

    // 1. Wrap over a 1000-sample window on channel 0.
    cnt_up = 4'b0001;
    pulses = 0;
    for (int i = 0; i < 999; i++) begin
      step();
      pulses += int'(done_pulse[0]);
    end
    check_value("wrap_999", 64'(cnt(0)), 64'd999);
    check_value("wrap_999_flag", 64'(rollover_flag[0]), 64'd0);
    step();
    pulses += int'(done_pulse[0]);
    check_value("wrap_1000", 64'(cnt(0)), 64'd1000);
    check_value("wrap_flag", 64'(rollover_flag[0]), 64'd1);
    check_value("wrap_pulse", 64'(done_pulse[0]), 64'd1);
    check_value("wrap_pulse_count", 64'(pulses), 64'd1);
    cnt_up = 4'b0000;
    step();
    check_value("wrap_hold_pulse", 64'(done_pulse[0]), 64'd0);
    check_value("wrap_hold_flag", 64'(rollover_flag[0]), 64'd1);
    cnt_up = 4'b0001;
    step();
    check_value("wrap_to_1", 64'(cnt(0)), 64'd1);
    check_value("wrap_to_1_flag", 64'(rollover_flag[0]), 64'd0);
    check_value("others_zero", 64'(count[NC*NB-1:NB]), 64'd0);

    // 2. One-shot with overrun on channel 1.
    clear_all();
    mode = 1'b1; rollover_val = 10'd5; cnt_up = 4'b0010;
    for (int i = 0; i < 5; i++) step();
    check_value("os_5", 64'(cnt(1)), 64'd5);
    check_value("os_flag", 64'(rollover_flag[1]), 64'd1);
    check_value("os_no_ovr", 64'(overrun[1]), 64'd0);
    step();
    check_value("os_ovr6", 64'(overrun[1]), 64'd1);
    check_value("os_pulse_gone", 64'(done_pulse[1]), 64'd0);
    step(); step();
    check_value("os_hold", 64'(cnt(1)), 64'd5);
    check_value("os_flag_hold", 64'(rollover_flag[1]), 64'd1);
    cnt_up = 4'b0000; clear = 4'b0010;
    step();
    clear = 4'b0000;
    check_value("os_clr", 64'({cnt(1), rollover_flag[1], overrun[1]}), 64'd0);

    // 3. Clear wins over a simultaneous strobe.
    mode = 1'b0; rollover_val = 10'd1000; cnt_up = 4'b0100;
    for (int i = 0; i < 3; i++) step();
    check_value("clrpri_3", 64'(cnt(2)), 64'd3);
    clear = 4'b0100;
    step();
    clear = 4'b0000; cnt_up = 4'b0000;
    check_value("clrpri_cnt", 64'(cnt(2)), 64'd0);
    check_value("clrpri_pulse", 64'(done_pulse[2]), 64'd0);

    // 4. all_done rises only when the last channel completes.
    clear_all();
    mode = 1'b1; rollover_val = 10'd3;
    for (int ch = 0; ch < 3; ch++) begin
      cnt_up = 4'(1 << ch);
      for (int i = 0; i < 3; i++) step();
    end
    cnt_up = 4'b1000;
    step(); step();
    check_value("alld_early", 64'(all_done), 64'd0);
    step();
    check_value("alld_rise", 64'(all_done), 64'd1);
    cnt_up = 4'b0000;
    step();
    check_value("alld_stay", 64'(all_done), 64'd1);
    clear = 4'b0010;
    step();
    clear = 4'b0000;
    check_value("alld_fall", 64'(all_done), 64'd0);

    // 5a. rollover_val == 0 disables all channels.
    clear_all();
    mode = 1'b0; rollover_val = 10'd0; cnt_up = 4'b1111;
    for (int i = 0; i < 5; i++) step();
    check_value("dis_count", 64'(count), 64'd0);
    check_value("dis_flags", 64'({rollover_flag, done_pulse, all_done}), 64'd0);

    // 5b. Maximum window, wrap mode.
    rollover_val = 10'd1023; cnt_up = 4'b0001;
    for (int i = 0; i < 1023; i++) step();
    check_value("max_cnt", 64'(cnt(0)), 64'd1023);
    check_value("max_flag", 64'(rollover_flag[0]), 64'd1);
    step();
    check_value("max_wrap", 64'(cnt(0)), 64'd1);

    // 5c. Window of one in wrap mode pulses once only.
    clear_all();
    rollover_val = 10'd1; cnt_up = 4'b1000; pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      pulses += int'(done_pulse[3]);
    end
    check_value("rv1_cnt", 64'(cnt(3)), 64'd1);
    check_value("rv1_pulses", 64'(pulses), 64'd1);

    // 6. Asynchronous reset mid-count.
    clear_all();
    rollover_val = 10'd1000; cnt_up = 4'b0001;
    for (int i = 0; i < 400; i++) step();
    check_value("ar_400", 64'(cnt(0)), 64'd400);
    cnt_up = 4'b0000;
    #2;
    n_rst = 1'b0;
    #1;
    check_value("ar_count", 64'(count), 64'd0);
    check_value("ar_flags", 64'({rollover_flag, done_pulse, overrun, all_done}), 64'd0);
    #1;
    n_rst = 1'b1;
    cnt_up = 4'b0001;
    step();
    check_value("ar_resume", 64'(cnt(0)), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_multi_sample_counter

// File: doc/multi_sample_counter.md
Name: multi_sample_counter

Overview:
Parametrised, multi-channel successor to the single-channel 1000-sample counter. Each of NUM_CH channels counts its own sample strobes up to a shared, run-time-programmable rollover value. Each channel flags window completion and can either wrap or stop (one-shot). Sits between the per-channel sample datapaths and the control FSM, which consumes per-channel flags and the aggregate all_done.

Parameters:
NUM_BITS, 10, width of each channel's count and of rollover_val
NUM_CH, 4, number of independent counter channels (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
n_rst  input  1  asynchronous active-low reset
cnt_up  input  NUM_CH  per-channel count enable (one sample strobe per cycle)
clear  input  NUM_CH  per-channel synchronous clear
mode  input  1  0 = wrap (continuous windows), 1 = one-shot (stop at rollover)
rollover_val  input  NUM_BITS  shared window length, e.g. 1000
count  output  NUM_CH*NUM_BITS  packed counts; channel i at [i*NUM_BITS +: NUM_BITS]
rollover_flag  output  NUM_CH  registered; high while channel count == rollover_val
done_pulse  output  NUM_CH  registered one-cycle pulse on the cycle count first becomes rollover_val
overrun  output  NUM_CH  sticky; set on cnt_up while a one-shot channel is held at rollover
all_done  output  1  AND of rollover_flag over all channels, combinational from registered flags

Behaviour:
- Reset (n_rst=0, asynchronous): every count=0, rollover_flag=0, done_pulse=0, overrun=0. all_done is therefore 0.
- Channels are fully independent. Only mode and rollover_val are shared.
- Per-channel priority, highest first: clear, rollover_val==0, cnt_up, hold.
- clear=1: next count=0, flag=0, pulse=0, overrun=0, regardless of cnt_up.
- rollover_val==0: channel disabled. Count holds at 0, flag=0, pulse=0, and cnt_up is ignored.
- cnt_up=1, mode=0 (wrap):
  - if count >= rollover_val, next count=1;
  - otherwise next count=count+1.
  - The sequence is 1..rollover_val,1,2,... with 0 reached only via reset or clear.
- cnt_up=1, mode=1 (one-shot):
  - if count < rollover_val, next count=count+1;
  - if count >= rollover_val, count holds and overrun is set.
- cnt_up=0: count holds.
- rollover_flag: registered version of (next count == rollover_val), so it is valid in the same cycle count shows rollover_val. Latency is one clock from the final cnt_up edge.
- done_pulse: high for exactly one cycle when next count == rollover_val and current count != rollover_val.
  - In wrap mode with rollover_val==1, count stays at 1, so there is one pulse only, until clear.
- rollover_val lowered below a running count: wrap mode wraps to 1 on the next cnt_up; one-shot holds and sets overrun on cnt_up. No flag is raised until count == rollover_val exactly.
- rollover_val raised above a held one-shot count: the channel resumes counting on the next cnt_up. The flag drops on the next update.
- mode change mid-count: takes effect on the next cnt_up. Count is not reset.
- Max rollover_val (2^NUM_BITS-1): no arithmetic overflow is possible, because the wrap/hold check precedes the increment.
- Reset asserted mid-count: all state clears immediately (asynchronous). Counting resumes from 0 on the first cnt_up after release.

Decomposition:
- Shared package msc_pkg:
  - localparam mode encodings MODE_WRAP=1'b0, MODE_ONESHOT=1'b1;
  - default NUM_BITS/NUM_CH constants;
  - DEFAULT_WINDOW=1000.
- One natural sub-module: chan_counter (NUM_BITS parameter). It holds a single channel's count, flag, pulse and overrun logic.
- multi_sample_counter instantiates NUM_CH chan_counter instances in a generate loop, packs count, and forms all_done.

Test Plan:
1. Reset then wrap: NUM_CH=4, rollover_val=1000, mode=0, cnt_up[0] held 1000 cycles -> count0=1000, flag0=1, one done_pulse[0] on that cycle. The next cnt_up gives count0=1 and flag0=0. Other channels stay 0.
2. One-shot/overrun: rollover_val=5, mode=1, cnt_up[1] high 8 cycles -> count1 stops at 5, flag1 stays 1, overrun[1]=1 from the 6th strobe. clear[1] -> count1=0, flag1=0, overrun[1]=0.
3. Clear priority: clear[2]=1 and cnt_up[2]=1 in the same cycle at count2=3 -> count2=0, no pulse.
4. all_done: rollover_val=3, mode=1, channels strobed 3 times at staggered times -> all_done rises only in the cycle the last channel reaches 3, and stays high until any channel is cleared.
5. Edge values: rollover_val=0 with cnt_up all ones -> counts stay 0, no flags. Then rollover_val=1023, NUM_BITS=10, wrap -> count reaches 1023, flag=1, next strobe gives 1.
6. Async reset mid-count: count0=400, n_rst pulsed low between clock edges -> all outputs 0 immediately; after release, 1 strobe gives count0=1.
